pkt_router_n: RTL and testbench

PKT_ROUTER_N -- requirements
Module: pkt_router_n

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_fifo.sv | 64 ++++++
 rtl/pkt_router_n.sv | 91 +++++++++
 tb/tb_pkt_router_n.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg: shared defaults and helpers for pkt_router_n | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package router_pkg;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned N_OUT_DEF      = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned DROP_CNT_W     = 8;

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_fifo.sv
// ---------------------------------------------------------------------------
// router_fifo: first-word-fall-through FIFO, one per output channel | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module router_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/pkt_router_n.sv
// ---------------------------------------------------------------------------
// pkt_router_n: unicast/broadcast word router into N_OUT output FIFOs | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pkt_router_n
  import router_pkg::*;
#(
  parameter  int unsigned DATA_W     = DATA_W_DEF,
  parameter  int unsigned N_OUT      = N_OUT_DEF,
  parameter  int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned DEST_W     = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [DEST_W-1:0]       dest_addr,
  input  logic                    bcast,
  output logic                    in_ready,
  output logic [N_OUT*DATA_W-1:0] data_out,
  output logic [N_OUT-1:0]        valid_out,
  input  logic [N_OUT-1:0]        ready_out,
  output logic [N_OUT-1:0]        fifo_full,
  output logic                    drop_err,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  logic             rdy_en_q;
  logic             drop_err_q, drop_err_d;
  drop_cnt_t        drop_cnt_q, drop_cnt_d;
  logic [N_OUT-1:0] dest_hit;
  logic [N_OUT-1:0] push_vec;
  logic [N_OUT-1:0] full_w;
  logic [N_OUT-1:0] empty_w;
  logic [31:0]      dest_ext;
  logic             illegal;
  logic             accept;

  assign dest_ext = 32'(dest_addr);
  assign illegal  = !bcast && (dest_ext >= N_OUT);

  // rdy_en_q keeps the input closed through the first edge after reset release.
  assign in_ready = rdy_en_q &&
                    (bcast ? ~|full_w : (illegal || ~|(full_w & dest_hit)));
  assign accept   = in_valid && in_ready;
  assign push_vec = accept ? (bcast ? {N_OUT{1'b1}} : dest_hit) : '0;

  always_comb begin
    drop_err_d = accept && illegal;
    drop_cnt_d = drop_err_d ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q   <= 1'b0;
      drop_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      drop_err_q <= drop_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_err  = drop_err_q;
  assign drop_cnt  = drop_cnt_q;
  assign fifo_full = full_w;
  assign valid_out = ~empty_w;

  for (genvar i = 0; i < N_OUT; i++) begin : g_chan
    assign dest_hit[i] = (dest_addr == DEST_W'(i));

    router_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_vec[i]),
      .wdata (data_in),
      .pop   (ready_out[i]),
      .full  (full_w[i]),
      .empty (empty_w[i]),
      .head  (data_out[i*DATA_W +: DATA_W])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pkt_router_n.sv
// ---------------------------------------------------------------------------
// tb_pkt_router_n: scoreboard bench for pkt_router_n (N_OUT=4 and N_OUT=3) | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pkt_router_n;

  logic clk = 1'b0;
  logic rst;

  logic        a_in_valid, a_bcast, a_in_ready, a_drop_err;
  logic [7:0]  a_data_in, a_drop_cnt;
  logic [1:0]  a_dest;
  logic [31:0] a_data_out;
  logic [3:0]  a_valid_out, a_ready_out, a_fifo_full;

  logic        b_in_valid, b_bcast, b_in_ready, b_drop_err;
  logic [7:0]  b_data_in, b_drop_cnt;
  logic [1:0]  b_dest;
  logic [23:0] b_data_out;
  logic [2:0]  b_valid_out, b_ready_out, b_fifo_full;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_a[4][$];
  logic [7:0] exp_b[3][$];

  always #5 clk = ~clk;

  pkt_router_n #(.DATA_W(8), .N_OUT(4), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .data_in(a_data_in),
    .dest_addr(a_dest), .bcast(a_bcast), .in_ready(a_in_ready),
    .data_out(a_data_out), .valid_out(a_valid_out), .ready_out(a_ready_out),
    .fifo_full(a_fifo_full), .drop_err(a_drop_err), .drop_cnt(a_drop_cnt)
  );

  pkt_router_n #(.DATA_W(8), .N_OUT(3), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .data_in(b_data_in),
    .dest_addr(b_dest), .bcast(b_bcast), .in_ready(b_in_ready),
    .data_out(b_data_out), .valid_out(b_valid_out), .ready_out(b_ready_out),
    .fifo_full(b_fifo_full), .drop_err(b_drop_err), .drop_cnt(b_drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a word is consumed on the next rising edge whenever valid && ready.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (a_valid_out[i] && a_ready_out[i]) begin
        if (exp_a[i].size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL A ch%0d unexpected word: got %0h, expected none", i, a_data_out[i*8 +: 8]);
        end else begin
          chk($sformatf("A ch%0d data", i), 32'(a_data_out[i*8 +: 8]), 32'(exp_a[i].pop_front()));
        end
      end else if (!a_valid_out[i]) begin
        chk($sformatf("A ch%0d empty slice", i), 32'(a_data_out[i*8 +: 8]), 32'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (b_valid_out[i] && b_ready_out[i]) begin
        if (exp_b[i].size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL B ch%0d unexpected word: got %0h, expected none", i, b_data_out[i*8 +: 8]);
        end else begin
          chk($sformatf("B ch%0d data", i), 32'(b_data_out[i*8 +: 8]), 32'(exp_b[i].pop_front()));
        end
      end
    end
  end

  task automatic send(input logic bc, input logic [1:0] dest, input logic [7:0] d,
                      input logic [3:0] rdy, input logic exp_rdy);
    @(posedge clk);
    #1;
    a_in_valid  = 1'b1;
    a_bcast     = bc;
    a_dest      = dest;
    a_data_in   = d;
    a_ready_out = rdy;
    @(negedge clk);
    chk($sformatf("A in_ready word %0h", d), 32'(a_in_ready), 32'(exp_rdy));
    if (exp_rdy) begin
      if (bc) begin
        for (int k = 0; k < 4; k++) exp_a[k].push_back(d);
      end else begin
        exp_a[dest].push_back(d);
      end
    end
  endtask

  task automatic idle(input logic [3:0] rdy);
    @(posedge clk);
    #1;
    a_in_valid  = 1'b0;
    a_bcast     = 1'b0;
    a_ready_out = rdy;
  endtask

  initial begin
    rst = 1'b0;
    a_in_valid = 1'b0; a_bcast = 1'b0; a_dest = 2'd0; a_data_in = 8'h00; a_ready_out = 4'h0;
    b_in_valid = 1'b0; b_bcast = 1'b0; b_dest = 2'd0; b_data_in = 8'h00; b_ready_out = 3'b111;
    #2;
    chk("reset valid_out", 32'(a_valid_out), 32'd0);
    chk("reset fifo_full", 32'(a_fifo_full), 32'd0);
    chk("reset data_out", a_data_out, 32'd0);
    chk("reset drop_cnt", 32'(b_drop_cnt), 32'd0);
    chk("reset drop_err", 32'(b_drop_err), 32'd0);
    chk("reset in_ready", 32'(a_in_ready), 32'd0);

    // Release; the first edge afterwards must not accept.
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1'b1; a_dest = 2'd0; a_data_in = 8'h11;
    #2;
    chk("in_ready before first edge", 32'(a_in_ready), 32'd0);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    chk("in_ready after first edge", 32'(a_in_ready), 32'd1);

    // Unicast to channel 2.
    send(1'b0, 2'd2, 8'hA5, 4'hF, 1'b1);
    idle(4'hF);
    chk("unicast valid_out", 32'(a_valid_out), 32'h4);
    chk("unicast slice2", 32'(a_data_out[23:16]), 32'hA5);
    @(posedge clk);
    #1;
    chk("unicast one cycle", 32'(a_valid_out), 32'h0);

    // Backpressure on channel 1, channel 0 still flows.
    for (int k = 0; k < 4; k++) send(1'b0, 2'd1, 8'(8'h10 + k), 4'b1101, 1'b1);
    send(1'b0, 2'd1, 8'h14, 4'b1101, 1'b0);
    chk("bp fifo_full", 32'(a_fifo_full), 32'h2);
    send(1'b0, 2'd0, 8'h20, 4'b1101, 1'b1);
    idle(4'b1101);
    repeat (3) @(posedge clk);
    #1;
    chk("bp full held", 32'(a_fifo_full), 32'h2);
    chk("bp slice1 stable", 32'(a_data_out[15:8]), 32'h10);
    idle(4'hF);
    repeat (6) @(posedge clk);

    // Broadcast, then broadcast refused while channel 3 is full.
    send(1'b1, 2'd2, 8'h3C, 4'h0, 1'b1);
    idle(4'h0);
    chk("bcast valid_out", 32'(a_valid_out), 32'hF);
    chk("bcast data_out", a_data_out, 32'h3C3C3C3C);
    for (int k = 1; k < 4; k++) send(1'b0, 2'd3, 8'(8'h30 + k), 4'h0, 1'b1);
    send(1'b1, 2'd0, 8'h77, 4'h0, 1'b0);
    idle(4'h0);
    chk("bcast refused full", 32'(a_fifo_full), 32'h8);
    chk("bcast refused data", a_data_out, 32'h3C3C3C3C);
    idle(4'hF);
    repeat (6) @(posedge clk);

    // Full FIFO 0 with concurrent pop: push refused, then steady push/pop.
    for (int k = 0; k < 4; k++) send(1'b0, 2'd0, 8'(8'h40 + k), 4'h0, 1'b1);
    send(1'b0, 2'd0, 8'h44, 4'b0001, 1'b0);
    for (int k = 5; k < 11; k++) send(1'b0, 2'd0, 8'(8'h40 + k), 4'b0001, 1'b1);
    send(1'b0, 2'd0, 8'h4B, 4'h0, 1'b1);
    idle(4'h0);
    chk("pushpop refill full", 32'(a_fifo_full), 32'h1);
    idle(4'hF);
    repeat (6) @(posedge clk);

    // Illegal destination on the 3-channel router.
    @(posedge clk);
    #1;
    b_in_valid = 1'b1; b_dest = 2'd3; b_data_in = 8'h99;
    @(negedge clk);
    chk("B illegal in_ready", 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    chk("B drop_err pulse", 32'(b_drop_err), 32'd1);
    chk("B drop_cnt one", 32'(b_drop_cnt), 32'd1);
    chk("B no valid_out", 32'(b_valid_out), 32'd0);
    @(posedge clk);
    #1;
    chk("B drop_err ends", 32'(b_drop_err), 32'd0);
    chk("B drop_cnt held", 32'(b_drop_cnt), 32'd1);
    b_in_valid = 1'b1; b_dest = 2'd2; b_data_in = 8'h5A;
    @(negedge clk);
    chk("B legal in_ready", 32'(b_in_ready), 32'd1);
    exp_b[2].push_back(8'h5A);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    chk("B legal valid_out", 32'(b_valid_out), 32'h4);
    // Saturation: 260 more drops from a count of 1.
    b_in_valid = 1'b1; b_dest = 2'd3;
    repeat (260) @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    chk("B drop_cnt saturates", 32'(b_drop_cnt), 32'd255);

    // Reset with two words queued on channel 0.
    send(1'b0, 2'd0, 8'h61, 4'h0, 1'b1);
    send(1'b0, 2'd0, 8'h62, 4'h0, 1'b1);
    idle(4'h0);
    chk("pre-reset valid_out", 32'(a_valid_out), 32'h1);
    #3;
    rst = 1'b0;
    exp_a[0].delete();
    #1;
    chk("mid reset valid_out", 32'(a_valid_out), 32'h0);
    chk("mid reset data_out", a_data_out, 32'h0);
    chk("mid reset fifo_full", 32'(a_fifo_full), 32'h0);
    chk("mid reset in_ready", 32'(a_in_ready), 32'h0);
    chk("mid reset drop_cnt", 32'(b_drop_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    a_ready_out = 4'hF;
    repeat (5) @(posedge clk);
    send(1'b0, 2'd0, 8'h70, 4'hF, 1'b1);
    idle(4'hF);
    repeat (3) @(posedge clk);

    @(negedge clk);
    chk("A queues drained", 32'(exp_a[0].size() + exp_a[1].size() + exp_a[2].size() + exp_a[3].size()), 32'd0);
    chk("B queues drained", 32'(exp_b[0].size() + exp_b[1].size() + exp_b[2].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
